// File: rtl/tlk2711_pkg.sv
// Shared types and constants for the TLK2711 transmit framer.
// Latency: n/a (package only).
// Backpressure: n/a; holds the FSM/mode enums, K-code words and PRBS-15 helper.
package tlk2711_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_SOF,
      ST_HDR,
      ST_PAY,
      ST_EOF,
      ST_GAP
   } state_e;

   typedef enum logic [1:0] {
      MODE_CNT   = 2'd0,
      MODE_PRBS  = 2'd1,
      MODE_FIXED = 2'd2,
      MODE_WALK  = 2'd3
   } mode_e;

   localparam logic [15:0] K_IDLE = 16'hC5BC;
   localparam logic [15:0] K_SOF  = 16'h50FB;
   localparam logic [15:0] K_EOF  = 16'h50FD;

   localparam logic [14:0] PRBS_SEED = 15'h7FFF;

   // Runs x^15+x^14+1 for 16 bit-steps. Returns {next_state, word}; the
   // first generated bit lands in word[15].
   function automatic logic [30:0] prbs15_step16(input logic [14:0] s);
      logic [14:0] st;
      logic [15:0] w;
      logic        nb;
      st = s;
      w  = '0;
      for (int i = 0; i < 16; i++) begin
         nb = st[14] ^ st[13];
         st = {st[13:0], nb};
         w  = {w[14:0], nb};
      end
      return {st, w};
   endfunction

endpackage

// File: rtl/tlk2711_lane_gen.sv
// Per-lane payload word generator (counter / PRBS-15 / fixed / walking-one).
// Latency: combinational word for the index presented; PRBS state updates on clk.
// Backpressure: none; the LFSR only moves when adv_i is high, reseeds on reseed_i.
// Ports: clk/rst, mode_i, pattern_i (fixed word), pay_idx_i (payload index n),
//        reseed_i (SOF strobe), adv_i (payload word consumed), word_o.
module tlk2711_lane_gen
   import tlk2711_pkg::*;
#(
   parameter int LANE = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  mode_e       mode_i,
   input  logic [15:0] pattern_i,
   input  logic [15:0] pay_idx_i,
   input  logic        reseed_i,
   input  logic        adv_i,
   output logic [15:0] word_o
);

   localparam logic [14:0] LANE_SEED = PRBS_SEED ^ 15'(LANE);
   localparam logic [15:0] LANE_OFS  = 16'(LANE << 12);
   localparam logic [3:0]  LANE_LO   = 4'(LANE);

   logic [14:0] lfsr_q, lfsr_d, lfsr_nxt;
   logic [15:0] prbs_word;
   logic [3:0]  walk_sh;

   always_comb begin
      {lfsr_nxt, prbs_word} = prbs15_step16(lfsr_q);
      lfsr_d = lfsr_q;
      if (reseed_i) begin
         lfsr_d = LANE_SEED;
      end else if (adv_i) begin
         lfsr_d = lfsr_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= LANE_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   // 4-bit sum wraps naturally, giving (n+k) mod 16.
   assign walk_sh = pay_idx_i[3:0] + LANE_LO;

   always_comb begin
      word_o = '0;
      case (mode_i)
         MODE_CNT:   word_o = LANE_OFS + pay_idx_i;
         MODE_PRBS:  word_o = prbs_word;
         MODE_FIXED: word_o = pattern_i;
         MODE_WALK:  word_o = 16'h0001 << walk_sh;
         default:    word_o = '0;
      endcase
   end

endmodule

// File: rtl/tlk2711_tx_gen.sv
// Multi-lane TLK2711 transmit framer: sync idles, SOF, header, payload, EOF, gap.
// Latency: start accepted at edge T gives the first SYNC word and o_busy at T+1.
// Backpressure: none; stop finishes the current frame (aborts at once in SYNC) then acks.
// Ports: clk/rst, i_start, i_stop, i_mode, i_pattern -> o_txd/o_tkmsb/o_tklsb per lane,
//        o_busy, o_stop_ack, o_frame_cnt, plus constant TLK2711 control pins.
module tlk2711_tx_gen
   import tlk2711_pkg::*;
#(
   parameter int LANES     = 2,
   parameter int FRAME_LEN = 256,
   parameter int SYNC_LEN  = 16,
   parameter int IDLE_GAP  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   input  logic                 i_stop,
   input  logic [1:0]           i_mode,
   input  logic [15:0]          i_pattern,
   output logic                 o_stop_ack,
   output logic                 o_busy,
   output logic [LANES*16-1:0]  o_txd,
   output logic [LANES-1:0]     o_tkmsb,
   output logic [LANES-1:0]     o_tklsb,
   output logic [31:0]          o_frame_cnt,
   output logic                 o_enable,
   output logic                 o_lckrefn,
   output logic                 o_loopen,
   output logic                 o_prbsen,
   output logic                 o_testen
);

   localparam logic [15:0] SYNC_LAST = 16'(SYNC_LEN - 1);
   localparam logic [15:0] PAY_LAST  = 16'(FRAME_LEN - 1);
   localparam logic [15:0] GAP_LAST  = 16'(IDLE_GAP - 1);

   state_e                state_q, state_d;
   logic [15:0]           cnt_q, cnt_d;
   logic                  stop_pend_q, stop_pend_d;
   logic                  stop_prev_q;
   mode_e                 mode_q, mode_d;
   logic [31:0]           frame_cnt_q, frame_cnt_d;
   logic                  ack_q, ack_d;
   logic                  busy_q;
   logic [LANES*16-1:0]   txd_q, txd_d;
   logic [LANES-1:0]      tkl_q, tkl_d;
   logic                  stop_req, stop_rise;
   logic [15:0]           line_word;
   logic                  line_k, is_pay;
   logic                  reseed, adv;
   logic [15:0]           lane_word [LANES];

   // Next-state, counters and stop handshake.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stop_pend_d = stop_pend_q;
      mode_d      = mode_q;
      frame_cnt_d = frame_cnt_q;
      ack_d       = 1'b0;
      stop_req    = stop_pend_q | i_stop;
      // Only a new stop request acks from IDLE, so a held level stop
      // still produces a single ack.
      stop_rise   = i_stop & ~stop_prev_q;

      case (state_q)
         ST_IDLE: begin
            if (stop_rise) begin
               ack_d = 1'b1;
            end else if (i_start && !i_stop) begin
               state_d = ST_SYNC;
               cnt_d   = '0;
               mode_d  = mode_e'(i_mode);
            end
         end
         ST_SYNC: begin
            if (stop_req) begin
               state_d = ST_IDLE;
            end else if (cnt_q == SYNC_LAST) begin
               state_d = ST_SOF;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_SOF: state_d = ST_HDR;
         ST_HDR: begin
            state_d = ST_PAY;
            cnt_d   = '0;
         end
         ST_PAY: begin
            if (cnt_q == PAY_LAST) begin
               state_d     = ST_EOF;
               frame_cnt_d = frame_cnt_q + 32'd1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_EOF: begin
            state_d = ST_GAP;
            cnt_d   = '0;
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = stop_req ? ST_IDLE : ST_SOF;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_q != ST_IDLE && i_stop) begin
         stop_pend_d = 1'b1;
      end
      if (state_q != ST_IDLE && state_d == ST_IDLE) begin
         ack_d       = 1'b1;
         stop_pend_d = 1'b0;
      end
   end

   // Line word for the state being entered, so the outputs stay registered
   // while still showing the first SYNC word one edge after start.
   always_comb begin
      line_word = K_IDLE;
      line_k    = 1'b1;
      is_pay    = 1'b0;
      txd_d     = '0;
      case (state_d)
         ST_SOF: line_word = K_SOF;
         ST_EOF: line_word = K_EOF;
         ST_HDR: begin
            line_word = frame_cnt_q[15:0];
            line_k    = 1'b0;
         end
         ST_PAY: begin
            is_pay = 1'b1;
            line_k = 1'b0;
         end
         default: line_word = K_IDLE;
      endcase
      for (int k = 0; k < LANES; k++) begin
         txd_d[16*k +: 16] = is_pay ? lane_word[k] : line_word;
      end
      tkl_d = {LANES{line_k}};
   end

   assign reseed = (state_d == ST_SOF);
   assign adv    = (state_d == ST_PAY);

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      tlk2711_lane_gen #(
         .LANE (k)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .mode_i    (mode_q),
         .pattern_i (i_pattern),
         .pay_idx_i (cnt_d),
         .reseed_i  (reseed),
         .adv_i     (adv),
         .word_o    (lane_word[k])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         stop_pend_q <= 1'b0;
         stop_prev_q <= 1'b0;
         mode_q      <= MODE_CNT;
         frame_cnt_q <= '0;
         ack_q       <= 1'b0;
         busy_q      <= 1'b0;
         txd_q       <= '0;
         tkl_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stop_pend_q <= stop_pend_d;
         stop_prev_q <= i_stop;
         mode_q      <= mode_d;
         frame_cnt_q <= frame_cnt_d;
         ack_q       <= ack_d;
         busy_q      <= (state_d != ST_IDLE);
         txd_q       <= txd_d;
         tkl_q       <= tkl_d;
      end
   end

   assign o_txd       = txd_q;
   assign o_tklsb     = tkl_q;
   assign o_tkmsb     = '0;     // no line word ever carries a K-code in the MSB byte
   assign o_busy      = busy_q;
   assign o_stop_ack  = ack_q;
   assign o_frame_cnt = frame_cnt_q;
   assign o_enable    = 1'b1;
   assign o_lckrefn   = 1'b1;
   assign o_loopen    = 1'b0;
   assign o_prbsen    = 1'b0;
   assign o_testen    = 1'b0;

endmodule

// File: tb/tb_tlk2711_tx_gen.sv
// Self-checking bench for tlk2711_tx_gen with a position-based stream model.
// Latency: n/a.
// Backpressure: n/a.
module tb_tlk2711_tx_gen;

   localparam int LANES     = 2;
   localparam int FRAME_LEN = 4;
   localparam int SYNC_LEN  = 2;
   localparam int IDLE_GAP  = 1;
   localparam int PERIOD    = FRAME_LEN + 3 + IDLE_GAP;
   localparam int EOF_OFS   = FRAME_LEN + 2;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                i_start = 1'b0;
   logic                i_stop = 1'b0;
   logic [1:0]          i_mode = 2'd0;
   logic [15:0]         i_pattern = 16'd0;
   logic                o_stop_ack, o_busy;
   logic [LANES*16-1:0] o_txd;
   logic [LANES-1:0]    o_tkmsb, o_tklsb;
   logic [31:0]         o_frame_cnt;
   logic                o_enable, o_lckrefn, o_loopen, o_prbsen, o_testen;

   int          checks = 0;
   int          errors = 0;
   int          m_mode = 0;
   logic [15:0] m_pat = 16'd0;
   int          m_fc = 0;
   logic [LANES*16-1:0] idle_vec;

   always #5 clk = ~clk;

   tlk2711_tx_gen #(
      .LANES(LANES), .FRAME_LEN(FRAME_LEN), .SYNC_LEN(SYNC_LEN), .IDLE_GAP(IDLE_GAP)
   ) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop), .i_mode(i_mode),
      .i_pattern(i_pattern), .o_stop_ack(o_stop_ack), .o_busy(o_busy), .o_txd(o_txd),
      .o_tkmsb(o_tkmsb), .o_tklsb(o_tklsb), .o_frame_cnt(o_frame_cnt),
      .o_enable(o_enable), .o_lckrefn(o_lckrefn), .o_loopen(o_loopen),
      .o_prbsen(o_prbsen), .o_testen(o_testen)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model (stream position p = words since start) ----
   function automatic logic [15:0] m_prbs(int k, int n);
      logic [14:0] s;
      logic [15:0] w;
      logic        nb;
      s = 15'h7FFF ^ 15'(k);
      w = '0;
      for (int i = 0; i < 16 * (n + 1); i++) begin
         nb = s[14] ^ s[13];
         s  = {s[13:0], nb};
         w  = {w[14:0], nb};
      end
      return w;
   endfunction

   function automatic logic [15:0] exp_word(int k, int p);
      int q, f, n;
      if (p < SYNC_LEN) return 16'hC5BC;
      q = p - SYNC_LEN;
      f = q % PERIOD;
      if (f == 0) return 16'h50FB;
      if (f == 1) return 16'(m_fc + q / PERIOD);
      if (f == EOF_OFS) return 16'h50FD;
      if (f > EOF_OFS) return 16'hC5BC;
      n = f - 2;
      case (m_mode)
         0:       return 16'((k << 12) + n);
         1:       return m_prbs(k, n);
         2:       return m_pat;
         default: return 16'(1 << ((n + k) % 16));
      endcase
   endfunction

   function automatic logic [LANES*16-1:0] exp_txd(int p);
      logic [LANES*16-1:0] v;
      for (int k = 0; k < LANES; k++) v[16*k +: 16] = exp_word(k, p);
      return v;
   endfunction

   function automatic logic [LANES-1:0] exp_tkl(int p);
      int f;
      if (p < SYNC_LEN) return {LANES{1'b1}};
      f = (p - SYNC_LEN) % PERIOD;
      return (f >= 1 && f <= FRAME_LEN + 1) ? {LANES{1'b0}} : {LANES{1'b1}};
   endfunction

   function automatic logic [31:0] exp_fc(int p);
      int q;
      q = p - SYNC_LEN;
      if (q < EOF_OFS) return 32'(m_fc);
      return 32'(m_fc + (q - EOF_OFS) / PERIOD + 1);
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      checks++; if (o_txd !== '0) begin errors++; $display("FAIL reset_txd: got %h want 0", o_txd); end
      checks++; if (o_tklsb !== '0) begin errors++; $display("FAIL reset_tklsb: got %b want 0", o_tklsb); end
      checks++; if (o_tkmsb !== '0) begin errors++; $display("FAIL reset_tkmsb: got %b want 0", o_tkmsb); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      checks++; if (o_stop_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", o_stop_ack); end
      checks++; if (o_frame_cnt !== 32'd0) begin errors++; $display("FAIL reset_fc: got %0d want 0", o_frame_cnt); end
      checks++;
      if ({o_enable, o_lckrefn, o_loopen, o_prbsen, o_testen} !== 5'b11000) begin
         errors++;
         $display("FAIL const_pins: got %b want 11000", {o_enable, o_lckrefn, o_loopen, o_prbsen, o_testen});
      end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (o_txd !== '0) begin errors++; $display("FAIL reset_hold_txd: got %h want 0", o_txd); end
      rst = 1'b0;
      tick();
      checks++; if (o_txd !== idle_vec) begin errors++; $display("FAIL post_reset_idle: got %h want %h", o_txd, idle_vec); end
      checks++; if (o_tklsb !== {LANES{1'b1}}) begin errors++; $display("FAIL post_reset_tklsb: got %b", o_tklsb); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", o_busy); end
      m_fc = 0;
   endtask

   task automatic test_plan_sequence();
      logic [15:0] l0 [12];
      int          c;
      l0 = '{16'hC5BC, 16'hC5BC, 16'h50FB, 16'h0000, 16'h0000, 16'h0001,
             16'h0002, 16'h0003, 16'h50FD, 16'hC5BC, 16'h50FB, 16'h0001};
      i_mode  = 2'd0;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int p = 0; p < 12; p++) begin
         checks++;
         if (o_txd[15:0] !== l0[p]) begin errors++; $display("FAIL plan_lane0 p=%0d: got %h want %h", p, o_txd[15:0], l0[p]); end
         checks++;
         if (o_busy !== 1'b1) begin errors++; $display("FAIL plan_busy p=%0d: got %b want 1", p, o_busy); end
         if (p >= 4 && p <= 7) begin
            checks++;
            if (o_txd[31:16] !== 16'h1000 + 16'(p - 4)) begin
               errors++; $display("FAIL plan_lane1 p=%0d: got %h want %h", p, o_txd[31:16], 16'h1000 + 16'(p - 4));
            end
         end
         if (p == 8) begin
            checks++;
            if (o_frame_cnt !== 32'd1) begin errors++; $display("FAIL plan_fc_eof: got %0d want 1", o_frame_cnt); end
         end
         i_stop = (p == 11);
         tick();
      end
      i_stop = 1'b0;
      c = 0;
      while (c < 40 && o_stop_ack !== 1'b1) begin
         tick();
         c++;
      end
      checks++;
      if (o_stop_ack !== 1'b1) begin
         errors++; $display("FAIL plan_ack_timeout: got no ack within 40 cycles");
      end else begin
         checks++; if (c !== 6) begin errors++; $display("FAIL plan_ack_time: got %0d cycles want 6", c); end
         checks++; if (o_frame_cnt !== 32'd2) begin errors++; $display("FAIL plan_fc_end: got %0d want 2", o_frame_cnt); end
         checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL plan_busy_end: got %b want 0", o_busy); end
      end
      tick();
      checks++; if (o_stop_ack !== 1'b0) begin errors++; $display("FAIL plan_ack_width: got %b want 0", o_stop_ack); end
      m_fc = 2;
   endtask

   // Random runs: mode latched at start while i_mode and i_start are
   // scrambled during the run; a single stop pulse at a chosen position.
   task automatic test_runs(input int n_runs);
      int stop_p, e_end, fr;
      logic [31:0] fc_end;
      for (int r = 0; r < n_runs; r++) begin
         m_mode = (r < 4) ? r : int'($urandom_range(0, 3));
         m_pat  = 16'($urandom);
         if (r == 4)      stop_p = 1;
         else if (r == 2) stop_p = SYNC_LEN + PERIOD + 3;
         else             stop_p = int'($urandom_range(SYNC_LEN, SYNC_LEN + 3 * PERIOD - 1));
         if (stop_p < SYNC_LEN) begin
            e_end  = stop_p;
            fc_end = 32'(m_fc);
         end else begin
            fr     = (stop_p - SYNC_LEN) / PERIOD;
            e_end  = SYNC_LEN + (fr + 1) * PERIOD - 1;
            fc_end = 32'(m_fc + fr + 1);
         end
         i_mode    = 2'(m_mode);
         i_pattern = m_pat;
         i_start   = 1'b1;
         tick();
         i_start = 1'b0;
         for (int p = 0; p <= e_end; p++) begin
            checks++;
            if (o_txd !== exp_txd(p)) begin errors++; $display("FAIL run%0d_txd p=%0d: got %h want %h", r, p, o_txd, exp_txd(p)); end
            checks++;
            if (o_tklsb !== exp_tkl(p) || o_tkmsb !== '0) begin
               errors++; $display("FAIL run%0d_kflags p=%0d: got %b/%b want %b/00", r, p, o_tklsb, o_tkmsb, exp_tkl(p));
            end
            checks++;
            if (o_frame_cnt !== exp_fc(p)) begin errors++; $display("FAIL run%0d_fc p=%0d: got %0d want %0d", r, p, o_frame_cnt, exp_fc(p)); end
            checks++;
            if (o_busy !== 1'b1 || o_stop_ack !== 1'b0) begin
               errors++; $display("FAIL run%0d_busy_ack p=%0d: got %b%b want 10", r, p, o_busy, o_stop_ack);
            end
            i_stop = (p == stop_p);
            if (p < e_end) begin
               i_mode  = 2'($urandom);
               i_start = ($urandom_range(0, 3) == 0);
            end else begin
               i_start = 1'b0;
            end
            tick();
         end
         i_stop  = 1'b0;
         i_start = 1'b0;
         checks++; if (o_stop_ack !== 1'b1) begin errors++; $display("FAIL run%0d_ack: got %b want 1", r, o_stop_ack); end
         checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL run%0d_busy_fall: got %b want 0", r, o_busy); end
         checks++; if (o_txd !== idle_vec) begin errors++; $display("FAIL run%0d_idle: got %h want %h", r, o_txd, idle_vec); end
         checks++; if (o_frame_cnt !== fc_end) begin errors++; $display("FAIL run%0d_fc_end: got %0d want %0d", r, o_frame_cnt, fc_end); end
         tick();
         checks++; if (o_stop_ack !== 1'b0) begin errors++; $display("FAIL run%0d_ack_width: got %b want 0", r, o_stop_ack); end
         m_fc = int'(fc_end);
      end
   endtask

   task automatic test_start_stop_same_cycle();
      i_start = 1'b1;
      i_stop  = 1'b1;
      tick();
      i_start = 1'b0;
      i_stop  = 1'b0;
      checks++; if (o_stop_ack !== 1'b1) begin errors++; $display("FAIL ss_ack: got %b want 1", o_stop_ack); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ss_busy c=%0d: got %b want 0", i, o_busy); end
         checks++; if (o_txd !== idle_vec) begin errors++; $display("FAIL ss_idle c=%0d: got %h want %h", i, o_txd, idle_vec); end
         checks++; if (o_frame_cnt !== 32'(m_fc)) begin errors++; $display("FAIL ss_fc c=%0d: got %0d want %0d", i, o_frame_cnt, m_fc); end
         tick();
         checks++; if (o_stop_ack !== 1'b0) begin errors++; $display("FAIL ss_ack_once c=%0d: got %b want 0", i, o_stop_ack); end
      end
   endtask

   task automatic test_reset_mid_frame();
      m_mode  = 0;
      i_mode  = 2'd0;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      repeat (SYNC_LEN + PERIOD + 3) tick();
      checks++; if (o_txd !== exp_txd(SYNC_LEN + PERIOD + 3)) begin errors++; $display("FAIL rmf_pre_txd: got %h want %h", o_txd, exp_txd(SYNC_LEN + PERIOD + 3)); end
      checks++; if (o_frame_cnt !== 32'(m_fc + 1)) begin errors++; $display("FAIL rmf_pre_fc: got %0d want %0d", o_frame_cnt, m_fc + 1); end
      #2 rst = 1'b1;
      #1;
      checks++; if (o_txd !== '0) begin errors++; $display("FAIL rmf_txd: got %h want 0", o_txd); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rmf_busy: got %b want 0", o_busy); end
      checks++; if (o_tklsb !== '0) begin errors++; $display("FAIL rmf_tklsb: got %b want 0", o_tklsb); end
      checks++; if (o_frame_cnt !== 32'd0) begin errors++; $display("FAIL rmf_fc: got %0d want 0", o_frame_cnt); end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      checks++; if (o_txd !== idle_vec) begin errors++; $display("FAIL rmf_idle: got %h want %h", o_txd, idle_vec); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rmf_busy_after: got %b want 0", o_busy); end
      checks++; if (o_frame_cnt !== 32'd0) begin errors++; $display("FAIL rmf_fc_after: got %0d want 0", o_frame_cnt); end
      m_fc = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_vec = {LANES{16'hC5BC}};
      test_reset();
      test_plan_sequence();
      test_runs(8);
      test_start_stop_same_cycle();
      test_reset_mid_frame();
      test_runs(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
